// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    // One buffered fetch: the byte PC and the instruction word read at it.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // addi x0, x0, 0 -- presented on id_instr whenever nothing is buffered.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Byte distance between consecutive instruction words.
    localparam logic [31:0] PC_STEP = 32'd4;

endpackage : fetch_pkg

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched (pc, instr) pairs.
// Flush empties the buffer and wins over a same-cycle push or pop.
// A pop while empty is ignored; a push while full only lands if a pop frees
// the head slot in the same cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  fetch_entry_t               wdata_i,
    output fetch_entry_t               rdata_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    fetch_entry_t     mem_q [DEPTH];

    logic pop_eff;
    logic push_eff;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Effective handshakes and next pointer/count values.
    always_comb begin
        pop_eff  = pop_i && !empty_o;
        push_eff = push_i && (!full_o || pop_eff);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_eff) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop_eff) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push_eff && !pop_eff) begin
                count_d = count_q + 1'b1;
            end else if (pop_eff && !push_eff) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; reset to NOP so the head never reads as X.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '{pc: 32'h0, instr: NOP_INSTR};
            end
        end else if (push_eff && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule : fetch_fifo

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads the asynchronous instruction
// memory, buffers (pc, instr) pairs and hands them to decode.
//
// Decode handshake: id_valid means the buffer head holds an entry; when
// id_valid && id_ready are both high at a rising edge the head is consumed.
// id_valid never depends on id_ready, and the id_* data stays stable while
// id_valid is high and id_ready is low.
//
// A redirect flushes the buffer (including an entry popped that cycle) and
// reloads the PC. A misaligned target sets the sticky fetch_fault and stops
// fetching until an aligned redirect or reset.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          IMEM_ADDR_WIDTH = 10,
    parameter int          FIFO_DEPTH      = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    output logic [IMEM_ADDR_WIDTH-1:0]  imem_addr,
    input  logic [31:0]                 imem_dout,
    input  logic                        redirect_valid,
    input  logic [31:0]                 redirect_pc,
    output logic                        id_valid,
    input  logic                        id_ready,
    output logic [31:0]                 id_instr,
    output logic [31:0]                 id_pc,
    output logic [31:0]                 id_pc_plus4,
    output logic                        fetch_fault
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]      pc_q, pc_d;
    logic             fault_q, fault_d;
    logic             push;
    logic             pop;
    fetch_entry_t     wr_entry;
    fetch_entry_t     head;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;

    // Word address: byte PC with the two offset bits dropped; upper bits alias.
    assign imem_addr   = pc_q[IMEM_ADDR_WIDTH+1:2];
    assign fetch_fault = fault_q;
    assign wr_entry    = '{pc: pc_q, instr: imem_dout};

    // Handshakes and next PC / fault state.
    always_comb begin
        pop     = !fifo_empty && id_ready;
        push    = !redirect_valid && !fault_q && (!fifo_full || pop);
        pc_d    = pc_q;
        fault_d = fault_q;
        if (redirect_valid) begin
            pc_d    = redirect_pc;
            fault_d = (redirect_pc[1:0] != 2'b00);
        end else if (push) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    // PC and sticky fault registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .wdata_i (wr_entry),
        .rdata_o (head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Decode-side outputs: head entry when valid, NOP at PC 0 when empty.
    always_comb begin
        id_valid    = !fifo_empty;
        id_instr    = NOP_INSTR;
        id_pc       = 32'h0;
        if (!fifo_empty) begin
            id_instr = head.instr;
            id_pc    = head.pc;
        end
        id_pc_plus4 = id_pc + PC_STEP;
    end

    // Occupancy can never exceed the buffer depth.
    a_count_bound: assert property (@(posedge clk) disable iff (!reset_n)
        fifo_count <= CNT_W'(FIFO_DEPTH));

endmodule : fetch_unit
